// File: rtl/ddr_burst_responder.sv
// ddr_burst_responder: serves DDR data-burst reads/writes and two-word jump-address reads against a simple backing memory
module ddr_burst_responder #(
    parameter int DATA_WIDTH     = 16,
    parameter int DDR_ADDR_WIDTH = 28,
    parameter int BURST_LEN      = 16,
    parameter int ADDR_STEP      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      DATA_read_req,
    input  logic                      DATA_store_req,
    input  logic                      JMP_ADDR_read_req,
    input  logic [DDR_ADDR_WIDTH-1:0] DATA_read_addr,
    input  logic [DDR_ADDR_WIDTH-1:0] DATA_write_addr,
    input  logic [DATA_WIDTH-1:0]     DATA_to_ddr,
    input  logic                      data_to_ddr_rdy,
    output logic [DATA_WIDTH-1:0]     DATA_to_cache,
    output logic [DDR_ADDR_WIDTH-1:0] JMP_ADDR_to_cache,
    output logic                      rd_burst_data_valid,
    output logic [9:0]                rd_cnt_data,
    output logic                      wr_burst_data_req,
    output logic [3:0]                state_interface_module,
    output logic [DDR_ADDR_WIDTH-1:0] mem_addr,
    output logic                      mem_rd_en,
    output logic                      mem_wr_en,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic                      mem_rdy,
    input  logic [DATA_WIDTH-1:0]     mem_rdata
);
    localparam int NW = $clog2(BURST_LEN + 1);

    typedef enum logic [3:0] {
        IDLE                 = 4'd0,
        MEM_READ_DATA        = 4'd5,
        MEM_READ_JMP         = 4'd6,
        MEM_WRITE_DATA_STORE = 4'd9,
        DONE                 = 4'd10
    } state_t;

    state_t                    state_q;
    logic [DDR_ADDR_WIDTH-1:0] base_q;
    logic [DDR_ADDR_WIDTH-1:0] addr_d;
    logic [NW-1:0]             n_q;
    logic                      rd_pend_q;
    logic                      valid_q;
    logic [9:0]                cnt_q;
    logic [DATA_WIDTH-1:0]     data_q;
    logic [DATA_WIDTH-1:0]     lo_q;
    logic [DDR_ADDR_WIDTH-1:0] jmp_q;
    logic                      rd_acc;
    logic                      wr_acc;

    assign state_interface_module = state_q;
    assign DATA_to_cache          = data_q;
    assign JMP_ADDR_to_cache      = jmp_q;
    assign rd_burst_data_valid    = valid_q;
    assign rd_cnt_data            = cnt_q;

    // Backing-memory command is a pure function of state and issue count, so a refused command stays put
    always_comb begin
        addr_d            = base_q + DDR_ADDR_WIDTH'(ADDR_STEP) * DDR_ADDR_WIDTH'(n_q);
        mem_rd_en         = (state_q == MEM_READ_DATA && n_q != NW'(BURST_LEN)) ||
                            (state_q == MEM_READ_JMP && n_q != NW'(2));
        wr_burst_data_req = state_q == MEM_WRITE_DATA_STORE;
        mem_wr_en         = wr_burst_data_req && data_to_ddr_rdy;
        mem_addr          = (mem_rd_en || mem_wr_en) ? addr_d : '0;
        mem_wdata         = mem_wr_en ? DATA_to_ddr : '0;
        rd_acc            = mem_rd_en && mem_rdy;
        wr_acc            = mem_wr_en && mem_rdy;
    end

    // Sequencer: request arbitration, beat counting, read-data capture and completion handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            base_q    <= '0;
            n_q       <= '0;
            rd_pend_q <= 1'b0;
            valid_q   <= 1'b0;
            cnt_q     <= '0;
            data_q    <= '0;
            lo_q      <= '0;
            jmp_q     <= '0;
        end else begin
            rd_pend_q <= rd_acc;
            valid_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    n_q   <= '0;
                    cnt_q <= '0;
                    if (DATA_store_req) begin
                        state_q <= MEM_WRITE_DATA_STORE;
                        base_q  <= DATA_write_addr;
                    end else if (DATA_read_req) begin
                        state_q <= MEM_READ_DATA;
                        base_q  <= DATA_read_addr;
                    end else if (JMP_ADDR_read_req) begin
                        state_q <= MEM_READ_JMP;
                        base_q  <= DATA_read_addr;
                    end
                end
                MEM_READ_DATA: begin
                    if (rd_acc) begin
                        n_q     <= n_q + 1'b1;
                        cnt_q   <= cnt_q + 10'd1;
                        valid_q <= 1'b1;
                    end
                    if (rd_pend_q) data_q <= mem_rdata;
                    if (rd_pend_q && n_q == NW'(BURST_LEN)) begin
                        cnt_q   <= cnt_q + 10'd1;
                        state_q <= DONE;
                    end
                end
                MEM_READ_JMP: begin
                    if (rd_acc) n_q <= n_q + 1'b1;
                    if (rd_pend_q && n_q == NW'(1)) lo_q <= mem_rdata;
                    if (rd_pend_q && n_q == NW'(2)) begin
                        jmp_q   <= {mem_rdata[DDR_ADDR_WIDTH-DATA_WIDTH-1:0], lo_q};
                        valid_q <= 1'b1;
                    end
                    if (valid_q) begin
                        cnt_q   <= 10'd1;
                        state_q <= DONE;
                    end
                end
                MEM_WRITE_DATA_STORE: begin
                    if (wr_acc) begin
                        n_q <= n_q + 1'b1;
                        if (n_q == NW'(BURST_LEN - 1)) state_q <= DONE;
                    end
                end
                DONE: begin
                    if (!DATA_read_req && !DATA_store_req && !JMP_ADDR_read_req) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ddr_burst_responder.sv
// tb_ddr_burst_responder: scoreboard bench for burst reads, jump reads, stalled stores, priority, reset and wrap
module tb_ddr_burst_responder;
    localparam int DW = 16;
    localparam int AW = 28;
    localparam int BL = 16;
    localparam int ST = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          DATA_read_req = 1'b0;
    logic          DATA_store_req = 1'b0;
    logic          JMP_ADDR_read_req = 1'b0;
    logic [AW-1:0] DATA_read_addr = '0;
    logic [AW-1:0] DATA_write_addr = '0;
    logic [DW-1:0] DATA_to_ddr = '0;
    logic          data_to_ddr_rdy = 1'b0;
    logic [DW-1:0] DATA_to_cache;
    logic [AW-1:0] JMP_ADDR_to_cache;
    logic          rd_burst_data_valid;
    logic [9:0]    rd_cnt_data;
    logic          wr_burst_data_req;
    logic [3:0]    state_interface_module;
    logic [AW-1:0] mem_addr;
    logic          mem_rd_en;
    logic          mem_wr_en;
    logic [DW-1:0] mem_wdata;
    logic          mem_rdy = 1'b1;
    logic [DW-1:0] mem_rdata;

    int checks = 0;
    int errors = 0;
    logic [AW-1:0] cur_base = '0;
    bit jmp_mode = 1'b0;

    typedef struct {
        logic [9:0]    cnt;
        logic [DW-1:0] data;
        bit            chk_data;
        logic [AW-1:0] jmp;
        bit            chk_jmp;
    } rd_exp_t;

    rd_exp_t       rd_q[$];
    logic [AW-1:0] ra_q[$];
    logic [AW+DW-1:0] wr_q[$];
    bit            data_pend = 1'b0;
    logic [DW-1:0] data_exp = '0;

    ddr_burst_responder dut (
        .clk(clk), .rst(rst),
        .DATA_read_req(DATA_read_req), .DATA_store_req(DATA_store_req),
        .JMP_ADDR_read_req(JMP_ADDR_read_req),
        .DATA_read_addr(DATA_read_addr), .DATA_write_addr(DATA_write_addr),
        .DATA_to_ddr(DATA_to_ddr), .data_to_ddr_rdy(data_to_ddr_rdy),
        .DATA_to_cache(DATA_to_cache), .JMP_ADDR_to_cache(JMP_ADDR_to_cache),
        .rd_burst_data_valid(rd_burst_data_valid), .rd_cnt_data(rd_cnt_data),
        .wr_burst_data_req(wr_burst_data_req), .state_interface_module(state_interface_module),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_wdata(mem_wdata), .mem_rdy(mem_rdy), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        logic [AW-1:0] d;
        if (jmp_mode) return (a == cur_base) ? 16'h1234 : 16'h0ABC;
        d = a - cur_base;
        return 16'hA000 + DW'(d >> 3);
    endfunction

    // Backing memory: one-cycle read latency
    always @(posedge clk) if (mem_rd_en && mem_rdy) mem_rdata <= mem_fn(mem_addr);

    // Monitor: pops expectations whenever the DUT presents a beat or command
    always @(negedge clk) begin
        rd_exp_t e;
        logic [AW+DW-1:0] w;
        if (!rst) begin
            data_pend = 1'b0;
        end else begin
            chk("rd_wr_exclusive", {63'd0, mem_rd_en && mem_wr_en}, 64'd0);
            if (data_pend) begin
                chk("data_to_cache", DATA_to_cache, data_exp);
                data_pend = 1'b0;
            end
            if (rd_burst_data_valid) begin
                if (rd_q.size() == 0) chk("valid_unexpected", rd_burst_data_valid, 0);
                else begin
                    e = rd_q.pop_front();
                    chk("rd_cnt_at_valid", rd_cnt_data, e.cnt);
                    if (e.chk_data) begin
                        data_pend = 1'b1;
                        data_exp  = e.data;
                    end
                    if (e.chk_jmp) chk("jmp_addr", JMP_ADDR_to_cache, e.jmp);
                end
            end
            if (mem_rd_en && mem_rdy) begin
                if (ra_q.size() == 0) chk("rd_unexpected", mem_rd_en, 0);
                else chk("rd_addr", mem_addr, ra_q.pop_front());
            end
            if (mem_wr_en && mem_rdy) begin
                if (wr_q.size() == 0) chk("wr_unexpected", mem_wr_en, 0);
                else begin
                    w = wr_q.pop_front();
                    chk("wr_addr", mem_addr, w[AW+DW-1:DW]);
                    chk("wr_data", mem_wdata, w[DW-1:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [3:0] s, input string name);
        int t = 0;
        while (state_interface_module != s && t < 200) begin
            step();
            t++;
        end
        chk(name, state_interface_module, s);
    endtask

    task automatic push_read(input logic [AW-1:0] base);
        rd_exp_t e;
        cur_base = base;
        jmp_mode = 1'b0;
        for (int n = 0; n < BL; n++) begin
            ra_q.push_back(base + AW'(n * ST));
            e.cnt = 10'(n + 1);
            e.data = 16'hA000 + DW'(n);
            e.chk_data = 1'b1;
            e.jmp = '0;
            e.chk_jmp = 1'b0;
            rd_q.push_back(e);
        end
    endtask

    task automatic finish_read();
        wait_state(4'd10, "read_done");
        chk("read_cnt_final", rd_cnt_data, 17);
        step();
        chk("read_cnt_hold", rd_cnt_data, 17);
        chk("read_done_hold", state_interface_module, 10);
        DATA_read_req = 1'b0;
        wait_state(4'd0, "read_idle");
        chk("read_queue_drained", rd_q.size() + ra_q.size(), 0);
    endtask

    task automatic read_burst(input logic [AW-1:0] base);
        push_read(base);
        DATA_read_addr = base;
        DATA_read_req = 1'b1;
        finish_read();
    endtask

    task automatic store_burst(input logic [AW-1:0] base, input logic [DW-1:0] dbase, input bit stall);
        int c = 0;
        int wb = 0;
        bit hit = 1'b0;
        bit acc = 1'b0;
        for (int n = 0; n < BL; n++) wr_q.push_back({base + AW'(n * ST), dbase + DW'(n)});
        DATA_write_addr = base;
        DATA_store_req = 1'b1;
        for (int t = 0; t < 200; t++) begin
            step();
            if (acc) wb++;
            if (wb == BL) break;
            DATA_to_ddr = dbase + DW'(wb);
            data_to_ddr_rdy = !(stall && wr_burst_data_req && (c == 3 || c == 7));
            if (stall && wr_burst_data_req && wb == 10 && !hit) begin
                mem_rdy = 1'b0;
                hit = 1'b1;
                #1 chk("stall_addr_held", mem_addr, base + AW'(10 * ST));
            end else mem_rdy = 1'b1;
            acc = wr_burst_data_req && data_to_ddr_rdy && mem_rdy;
            if (wr_burst_data_req) c++;
        end
        chk("store_beats", wb, BL);
        chk("store_done", state_interface_module, 10);
        chk("store_req_dropped", wr_burst_data_req, 0);
        data_to_ddr_rdy = 1'b0;
        mem_rdy = 1'b1;
        chk("store_queue_drained", wr_q.size(), 0);
    endtask

    initial begin
        rd_exp_t e;
        int t;
        step();
        chk("reset_outputs_zero", |{DATA_to_cache, JMP_ADDR_to_cache, rd_burst_data_valid, rd_cnt_data,
            wr_burst_data_req, state_interface_module, mem_addr, mem_rd_en, mem_wr_en, mem_wdata}, 0);
        step();
        rst = 1'b1;
        chk("first_cycle_no_cmd", mem_rd_en | mem_wr_en, 0);
        step();

        read_burst(28'h100);

        cur_base = 28'h40;
        jmp_mode = 1'b1;
        ra_q.push_back(28'h40);
        ra_q.push_back(28'h48);
        e.cnt = 10'd0; e.data = '0; e.chk_data = 1'b0; e.jmp = 28'hABC1234; e.chk_jmp = 1'b1;
        rd_q.push_back(e);
        DATA_read_addr = 28'h40;
        JMP_ADDR_read_req = 1'b1;
        wait_state(4'd10, "jmp_done");
        chk("jmp_cnt_after", rd_cnt_data, 1);
        chk("jmp_data_unchanged", DATA_to_cache, 16'hA00F);
        chk("jmp_addr_held", JMP_ADDR_to_cache, 28'hABC1234);
        JMP_ADDR_read_req = 1'b0;
        wait_state(4'd0, "jmp_idle");

        store_burst(28'h200, 16'h5000, 1'b1);
        DATA_store_req = 1'b0;
        wait_state(4'd0, "store_idle");

        DATA_read_addr = 28'h500;
        DATA_read_req = 1'b1;
        store_burst(28'h300, 16'h6000, 1'b0);
        step();
        step();
        chk("prio_done_both_high", state_interface_module, 10);
        DATA_store_req = 1'b0;
        step();
        step();
        chk("prio_done_read_high", state_interface_module, 10);
        DATA_read_req = 1'b0;
        wait_state(4'd0, "prio_idle");
        read_burst(28'h500);

        push_read(28'h100);
        DATA_read_addr = 28'h100;
        DATA_read_req = 1'b1;
        t = 0;
        while (!(rd_burst_data_valid && rd_cnt_data == 10'd6) && t < 100) begin
            step();
            t++;
        end
        chk("reach_beat6", rd_cnt_data, 6);
        #1 rst = 1'b0;
        #1 chk("midrst_outputs_zero", |{DATA_to_cache, JMP_ADDR_to_cache, rd_burst_data_valid, rd_cnt_data,
            wr_burst_data_req, state_interface_module, mem_addr, mem_rd_en, mem_wr_en, mem_wdata}, 0);
        rd_q.delete();
        ra_q.delete();
        wr_q.delete();
        step();
        chk("rst_no_cmd", mem_rd_en | mem_wr_en, 0);
        push_read(28'h100);
        rst = 1'b1;
        chk("release_no_cmd", mem_rd_en | mem_wr_en, 0);
        finish_read();

        read_burst(28'hFFFFFF8);

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end
endmodule
